// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first UART receiver with a two-flop input synchronizer and mid-bit sampling.
// Emits a one-cycle new_data_out pulse per good byte, or a framing_error_out pulse on a low stop bit.
module uart_rx_byte #(
   parameter int CLOCK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE     = 115_200
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_wire_in,
   output logic       new_data_out,
   output logic [7:0] data_byte_out,
   output logic       framing_error_out
);

   localparam int P     = CLOCK_FREQ_HZ / BAUD_RATE;
   localparam int HALF  = P / 2;
   localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(P - 1);

   generate
      if (P < 4) begin : g_bad_rate
         $error("uart_rx_byte: CLOCK_FREQ_HZ / BAUD_RATE must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic             rx_p0;
   logic             rx_p1;
   logic             rx_sync;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_nxt;
   logic [7:0]       shift;
   logic [7:0]       shift_nxt;
   logic [7:0]       byte_nxt;
   logic             new_nxt;
   logic             ferr_nxt;

   // Stage p0/p1: metastability synchronizer; idles high so reset never fakes a start bit.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= rx_wire_in;
         rx_p1 <= rx_p0;
      end
   end

   assign rx_sync = rx_p1;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state             <= S_IDLE;
         cnt               <= '0;
         bit_idx           <= 3'd0;
         shift             <= 8'h00;
         data_byte_out     <= 8'h00;
         new_data_out      <= 1'b0;
         framing_error_out <= 1'b0;
      end else begin
         state             <= state_nxt;
         cnt               <= cnt_nxt;
         bit_idx           <= bit_idx_nxt;
         shift             <= shift_nxt;
         data_byte_out     <= byte_nxt;
         new_data_out      <= new_nxt;
         framing_error_out <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      byte_nxt    = data_byte_out;
      new_nxt     = 1'b0;
      ferr_nxt    = 1'b0;

      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (!rx_sync) begin
               state_nxt = S_START;
            end
         end

         // Half a bit in, the line must still be low or the edge was a glitch.
         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (rx_sync) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt   = S_DATA;
                  bit_idx_nxt = 3'd0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rx_sync;
               bit_idx_nxt        = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (rx_sync) begin
                  byte_nxt  = shift;
                  new_nxt   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = S_WAIT_HIGH;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         // A line stuck low after a bad stop bit must go high before a new frame can start.
         S_WAIT_HIGH: begin
            cnt_nxt = '0;
            if (rx_sync) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at P=8: directed frames plus random traffic, checked per cycle
// against a frame-timing reference model built from the line history.
module tb_uart_rx_byte;

   localparam int CLK_HZ = 800;
   localparam int BAUD   = 100;
   localparam int P      = 8;
   localparam int HALF   = 4;
   localparam int MAXC   = 8000;
   localparam int NEVER  = 1 << 30;

   logic       clk_in     = 1'b0;
   logic       rst_in     = 1'b1;
   logic       rx_wire_in = 1'b1;
   logic       new_data_out;
   logic       framing_error_out;
   logic [7:0] data_byte_out;

   int checks = 0;
   int errors = 0;
   int ecnt   = 0;

   bit         line_a   [MAXC];
   bit         rst_a    [MAXC];
   logic       out_new  [MAXC];
   logic       out_ferr [MAXC];
   logic [7:0] out_byte [MAXC];
   bit         exp_new  [MAXC];
   bit         exp_ferr [MAXC];
   logic [7:0] exp_byte [MAXC];

   uart_rx_byte #(
      .CLOCK_FREQ_HZ(CLK_HZ),
      .BAUD_RATE    (BAUD)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rx_wire_in       (rx_wire_in),
      .new_data_out     (new_data_out),
      .data_byte_out    (data_byte_out),
      .framing_error_out(framing_error_out)
   );

   always #5 clk_in = ~clk_in;

   // Edge k records what the DUT sampled at edge k.
   always @(posedge clk_in) begin
      if (ecnt < MAXC) begin
         line_a[ecnt] <= rx_wire_in;
         rst_a[ecnt]  <= rst_in;
      end
      ecnt <= ecnt + 1;
   end

   // Outputs as they stand after edge ecnt-1.
   always @(negedge clk_in) begin
      if (ecnt > 0 && ecnt <= MAXC) begin
         out_new[ecnt-1]  <= new_data_out;
         out_ferr[ecnt-1] <= framing_error_out;
         out_byte[ecnt-1] <= data_byte_out;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [9:0] frame_bits(input logic [7:0] d, input logic stop);
      return {stop, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [9:0] bits, input int rst_at, output int t0);
      t0 = 0;
      for (int c = 0; c < 10 * P; c++) begin
         @(negedge clk_in);
         if (c == 0) t0 = ecnt;
         rx_wire_in = bits[c / P];
         rst_in     = (c == rst_at);
      end
   endtask

   task automatic idle(input logic v, input int n);
      repeat (n) begin
         @(negedge clk_in);
         rx_wire_in = v;
         rst_in     = 1'b0;
      end
   endtask

   function automatic int count_pulses(input int a, input int b, input bit ferr);
      int n = 0;
      for (int k = a; k <= b; k++) begin
         if (ferr ? (out_ferr[k] === 1'b1) : (out_new[k] === 1'b1)) n++;
      end
      return n;
   endfunction

   function automatic int next_rst_after(input int x, input int last);
      for (int k = x + 1; k <= last; k++) begin
         if (rst_a[k]) return k;
      end
      return NEVER;
   endfunction

   task automatic set_byte(input int from, input int last, input logic [7:0] v);
      for (int k = from; k <= last; k++) exp_byte[k] = v;
   endtask

   // Reference: find each start on the line history and apply the frame timing rules
   // (start checked at t0+HALF, bit i at t0+HALF+(i+1)P, stop at t0+HALF+9P, +2 sync delay).
   task automatic run_model(input int last);
      int s, cur, nr, t0, end_e, j;
      logic [7:0] v;
      bit do_rst;
      for (int k = 0; k <= last; k++) begin
         exp_new[k]  = 1'b0;
         exp_ferr[k] = 1'b0;
         exp_byte[k] = 8'h00;
      end
      s   = 0;
      cur = -1;
      while (1) begin
         nr = next_rst_after(cur, last);
         t0 = s;
         while (t0 <= last && line_a[t0]) t0++;
         do_rst = 1'b0;
         if (t0 + 2 + HALF + 9 * P + 2 > last) begin
            if (nr > last) break;
            do_rst = 1'b1;
         end else begin
            end_e = line_a[t0 + HALF] ? t0 + 2 + HALF : t0 + 2 + HALF + 9 * P;
            if (nr <= end_e) begin
               do_rst = 1'b1;
            end else if (line_a[t0 + HALF]) begin
               cur = end_e;
               s   = end_e - 1;
            end else begin
               for (int i = 0; i < 8; i++) v[i] = line_a[t0 + HALF + (i + 1) * P];
               if (line_a[t0 + HALF + 9 * P]) begin
                  exp_new[end_e] = 1'b1;
                  set_byte(end_e, last, v);
                  cur = end_e;
                  s   = end_e - 1;
               end else begin
                  exp_ferr[end_e] = 1'b1;
                  j = end_e - 1;
                  while (j <= last && !line_a[j]) j++;
                  if (j + 2 > last) break;
                  if (nr <= j + 2) begin
                     do_rst = 1'b1;
                  end else begin
                     cur = j + 2;
                     s   = j + 1;
                  end
               end
            end
         end
         if (do_rst) begin
            set_byte(nr, last, 8'h00);
            cur = nr;
            while (cur + 1 <= last && rst_a[cur + 1]) cur++;
            s = cur + 1;
         end
      end
   endtask

   initial begin
      int t0, t1, g0, last, r, gap, len, rst_at;
      int b2b[4];
      int pq[$];
      logic [7:0] d;
      logic [31:0] word;

      // Reset held for edges 0..2
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk("rst_new", {31'd0, new_data_out}, 32'd0);
      chk("rst_ferr", {31'd0, framing_error_out}, 32'd0);
      chk("rst_byte", {24'd0, data_byte_out}, 32'h00);

      // Good frame 0xA5
      idle(1'b1, 5);
      send_bits(frame_bits(8'hA5, 1'b1), -1, t0);
      idle(1'b1, 4);
      #1;
      chk("a5_pulse", {31'd0, out_new[t0 + 78]}, 32'd1);
      chk("a5_before", {31'd0, out_new[t0 + 77]}, 32'd0);
      chk("a5_after", {31'd0, out_new[t0 + 79]}, 32'd0);
      chk("a5_byte", {24'd0, out_byte[t0 + 78]}, 32'hA5);
      chk("a5_ferr", count_pulses(t0, t0 + 80, 1'b1), 32'd0);

      // Two-cycle glitch
      @(negedge clk_in);
      g0 = ecnt;
      rx_wire_in = 1'b0;
      @(negedge clk_in);
      rx_wire_in = 1'b0;
      idle(1'b1, 22);
      #1;
      chk("glitch_new", count_pulses(g0, g0 + 20, 1'b0), 32'd0);
      chk("glitch_ferr", count_pulses(g0, g0 + 20, 1'b1), 32'd0);
      chk("glitch_byte", {24'd0, out_byte[g0 + 20]}, 32'hA5);

      // Frame 0x3C with low stop bit, then line stuck low, then frame 0x11
      send_bits(frame_bits(8'h3C, 1'b0), -1, t0);
      idle(1'b0, 30);
      idle(1'b1, 10);
      #1;
      chk("ferr_pulse", {31'd0, out_ferr[t0 + 78]}, 32'd1);
      chk("ferr_count", count_pulses(t0, t0 + 118, 1'b1), 32'd1);
      chk("ferr_new", count_pulses(t0, t0 + 118, 1'b0), 32'd0);
      chk("ferr_byte", {24'd0, out_byte[t0 + 118]}, 32'hA5);
      send_bits(frame_bits(8'h11, 1'b1), -1, t1);
      idle(1'b1, 3);
      #1;
      chk("after_ferr_pulse", {31'd0, out_new[t1 + 78]}, 32'd1);
      chk("after_ferr_byte", {24'd0, out_byte[t1 + 78]}, 32'h11);

      // Back-to-back frames packed into one word
      for (int i = 0; i < 4; i++) send_bits(frame_bits(8'(i + 1), 1'b1), -1, b2b[i]);
      idle(1'b1, 4);
      #1;
      for (int k = b2b[0]; k <= b2b[3] + 81; k++) begin
         if (out_new[k] === 1'b1) pq.push_back(k);
      end
      chk("b2b_count", pq.size(), 32'd4);
      for (int i = 1; i < pq.size(); i++) chk("b2b_spacing", pq[i] - pq[i-1], 32'd80);
      word = 32'h0;
      for (int i = 0; i < 4; i++) word[8*i +: 8] = out_byte[b2b[i] + 78];
      chk("packed_word", word, 32'h04030201);

      // Reset in the middle of frame 0xFF, then frame 0x5A
      send_bits(frame_bits(8'hFF, 1'b1), 40, t0);
      idle(1'b1, 4);
      #1;
      chk("abort_new", count_pulses(t0, t0 + 82, 1'b0), 32'd0);
      chk("abort_ferr", count_pulses(t0, t0 + 82, 1'b1), 32'd0);
      chk("abort_byte", {24'd0, out_byte[t0 + 82]}, 32'h00);
      send_bits(frame_bits(8'h5A, 1'b1), -1, t1);
      idle(1'b1, 4);
      #1;
      chk("post_abort_count", count_pulses(t1, t1 + 82, 1'b0), 32'd1);
      chk("post_abort_byte", {24'd0, out_byte[t1 + 78]}, 32'h5A);

      // Random traffic: good frames, bad stops, glitches, mid-frame resets
      repeat (25) begin
         r   = $urandom_range(0, 9);
         gap = $urandom_range(0, 12);
         idle(1'b1, gap);
         if (r == 0) begin
            len = $urandom_range(1, HALF);
            idle(1'b0, len);
            idle(1'b1, HALF + 2);
         end else begin
            d      = 8'($urandom);
            rst_at = (r == 2) ? $urandom_range(0, 10 * P - 1) : -1;
            send_bits(frame_bits(d, r != 1), rst_at, t0);
            if (r == 1) idle(1'b0, $urandom_range(0, 15));
         end
      end
      idle(1'b1, 100);
      #1;

      last = ecnt - 1;
      run_model(last);
      for (int k = 0; k <= last; k++) begin
         chk($sformatf("cyc%0d", k),
             {22'd0, out_new[k], out_ferr[k], out_byte[k]},
             {22'd0, exp_new[k], exp_ferr[k], exp_byte[k]});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
